// File: rtl/bch_enc_scheduler_if.sv
// Bus bundle for bch_enc_scheduler: requester side, encoder side and codeword output.
// slave = scheduler view, master = surrounding transmit path / environment view.
interface bch_enc_scheduler_if #(
    parameter int NUM_REQ = 4
);
    localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0]    req_valid;
    logic [16*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]    req_ready;
    logic [15:0]           enc_data;
    logic                  enc_start;
    logic                  enc_done;
    logic [30:0]           enc_codeword;
    logic                  cw_valid;
    logic                  cw_ready;
    logic [30:0]           cw_data;
    logic [IDW-1:0]        cw_id;
    logic                  timeout_err;
    logic                  busy;

    modport slave (
        input  req_valid, req_data, enc_done, enc_codeword, cw_ready,
        output req_ready, enc_data, enc_start, cw_valid, cw_data, cw_id, timeout_err, busy
    );

    modport master (
        output req_valid, req_data, enc_done, enc_codeword, cw_ready,
        input  req_ready, enc_data, enc_start, cw_valid, cw_data, cw_id, timeout_err, busy
    );
endinterface

// File: rtl/bch_enc_scheduler.sv
// Round-robin sharing of one BCH(31,16) encoder among NUM_REQ requesters, one word in flight.
// Optional BCH_SCHED_STATS_EN adds saturating stat_words / stat_timeouts counters.
module bch_enc_scheduler #(
    parameter int NUM_REQ      = 4,
    parameter int START_CYCLES = 2,
    parameter int TIMEOUT      = 64
) (
    input  logic                      clk,
    input  logic                      reset,
    bch_enc_scheduler_if.slave        bus
`ifdef BCH_SCHED_STATS_EN
    ,
    output logic [15:0]               stat_words,
    output logic [7:0]                stat_timeouts
`endif
);
    localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CW  = $clog2(TIMEOUT);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, HOLD} state_t;

    state_t                    state_q;
    logic [IDW-1:0]            last_q;
    logic [IDW-1:0]            id_q;
    logic [CW-1:0]             cnt_q;
    logic [15:0]               enc_data_q;
    logic                      enc_start_q;
    logic                      cw_valid_q;
    logic [30:0]               cw_data_q;
    logic                      timeout_err_q;

    logic [NUM_REQ-1:0][15:0]  words;
    logic                      gnt_found;
    logic [IDW-1:0]            gnt_idx;
    logic [IDW-1:0]            cand;

    assign words = bus.req_data;

    // First valid requester strictly after last_q, wrapping around.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        cand      = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand = IDW'((int'(last_q) + i) % NUM_REQ);
            if (!gnt_found && bus.req_valid[cand]) begin
                gnt_found = 1'b1;
                gnt_idx   = cand;
            end
        end
    end

    assign bus.req_ready = (state_q == IDLE && gnt_found && !reset)
                         ? (NUM_REQ'(1) << gnt_idx) : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            last_q        <= IDW'(NUM_REQ - 1);
            id_q          <= '0;
            cnt_q         <= '0;
            enc_data_q    <= '0;
            enc_start_q   <= 1'b0;
            cw_valid_q    <= 1'b0;
            cw_data_q     <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            timeout_err_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (gnt_found) begin
                        enc_data_q  <= words[gnt_idx];
                        id_q        <= gnt_idx;
                        last_q      <= gnt_idx;
                        enc_start_q <= 1'b1;
                        cnt_q       <= '0;
                        state_q     <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (cnt_q == CW'(START_CYCLES - 1)) begin
                        enc_start_q <= 1'b0;
                        cnt_q       <= '0;
                        state_q     <= WAIT;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                WAIT: begin
                    // A done arriving on the last allowed cycle still wins over the timeout.
                    if (bus.enc_done) begin
                        cw_data_q  <= bus.enc_codeword;
                        cw_valid_q <= 1'b1;
                        state_q    <= HOLD;
                    end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                        timeout_err_q <= 1'b1;
                        state_q       <= IDLE;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                HOLD: begin
                    if (bus.cw_ready) begin
                        cw_valid_q <= 1'b0;
                        state_q    <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.enc_data    = enc_data_q;
    assign bus.enc_start   = enc_start_q;
    assign bus.cw_valid    = cw_valid_q;
    assign bus.cw_data     = cw_data_q;
    assign bus.cw_id       = id_q;
    assign bus.timeout_err = timeout_err_q;
    assign bus.busy        = (state_q != IDLE);

`ifdef BCH_SCHED_STATS_EN
    logic [15:0] stat_words_q, stat_words_d;
    logic [7:0]  stat_to_q, stat_to_d;

    always_comb begin
        stat_words_d = stat_words_q;
        stat_to_d    = stat_to_q;
        if (state_q == HOLD && bus.cw_ready && stat_words_q != '1)
            stat_words_d = stat_words_q + 16'd1;
        if (timeout_err_q && stat_to_q != '1)
            stat_to_d = stat_to_q + 8'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stat_words_q <= '0;
            stat_to_q    <= '0;
        end else begin
            stat_words_q <= stat_words_d;
            stat_to_q    <= stat_to_d;
        end
    end

    assign stat_words    = stat_words_q;
    assign stat_timeouts = stat_to_q;
`endif
endmodule

// File: tb/tb_bch_enc_scheduler.sv
// Directed bench for bch_enc_scheduler with a behavioural BCH(31,16) encoder beside it.
module tb_bch_enc_scheduler;
    localparam int NREQ    = 4;
    localparam int ENC_LAT = 3;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    bch_enc_scheduler_if #(.NUM_REQ(NREQ)) bus ();

`ifdef BCH_SCHED_STATS_EN
    logic [15:0] stat_words;
    logic [7:0]  stat_timeouts;
`endif

    bch_enc_scheduler #(.NUM_REQ(NREQ), .START_CYCLES(2), .TIMEOUT(64)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
`ifdef BCH_SCHED_STATS_EN
        ,
        .stat_words    (stat_words),
        .stat_timeouts (stat_timeouts)
`endif
    );

    int errors = 0;
    int checks = 0;
    int exp_words = 0;

    logic [15:0] wd [NREQ] = '{16'd65, 16'hA5C3, 16'h0000, 16'hFFFF};

    // Systematic BCH(31,16): g(x) = x^15+x^11+x^10+x^9+x^8+x^7+x^5+x^3+x^2+x+1
    function automatic logic [30:0] bch_cw(input logic [15:0] m);
        logic [14:0] r;
        logic fb;
        r = '0;
        for (int i = 15; i >= 0; i--) begin
            fb = m[i] ^ r[14];
            r  = {r[13:0], 1'b0};
            if (fb) r = r ^ 15'h0FAF;
        end
        return {m, r};
    endfunction

    // Encoder model: captures on enc_start rising, pulses done ENC_LAT edges later.
    logic        enc_en = 1'b1;
    logic        frc_done = 1'b0;
    logic        mdl_done = 1'b0;
    logic        prev_start = 1'b0;
    logic [30:0] mdl_cw = '0;
    int          mdl_cnt = 0;

    always @(posedge clk) begin
        prev_start <= bus.enc_start;
        mdl_done   <= 1'b0;
        if (bus.enc_start && !prev_start) begin
            mdl_cnt <= ENC_LAT;
            mdl_cw  <= bch_cw(bus.enc_data);
        end else if (mdl_cnt != 0) begin
            mdl_cnt <= mdl_cnt - 1;
            if (mdl_cnt == 1) mdl_done <= 1'b1;
        end
    end

    assign bus.enc_done     = (mdl_done & enc_en) | frc_done;
    assign bus.enc_codeword = frc_done ? 31'h7FFF_FFFF : (mdl_done ? mdl_cw : 31'h0);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Present mask, expect a one-hot grant, then take the accept edge.
    task automatic grant(input logic [3:0] mask, input int exp);
        bus.req_valid = mask;
        #1;
        for (int i = 0; i < 20 && bus.req_ready == '0; i++) begin
            @(negedge clk);
            #1;
        end
        chk("req_ready", 32'(bus.req_ready), 32'(4'b0001 << exp));
        @(posedge clk);
        #1;
        bus.req_valid = '0;
        chk("req_ready_after_accept", 32'(bus.req_ready), 32'd0);
    endtask

    // Called just after the accept edge; follows the word through to cw_valid.
    task automatic finish_word(input int exp);
        int starts = 0;
        int k;
        logic seen = 1'b0;
        for (k = 1; k <= 60; k++) begin
            @(negedge clk);
            if (bus.enc_start) begin
                starts++;
                chk("enc_data", 32'(bus.enc_data), 32'(wd[exp]));
            end
            if (bus.cw_valid) begin
                seen = 1'b1;
                break;
            end
        end
        chk("cw_valid_seen", 32'(seen), 32'd1);
        chk("accept_to_cw_latency", 32'(k), 32'd6);
        chk("start_cycles", 32'(starts), 32'd2);
        chk("cw_id", 32'(bus.cw_id), 32'(exp));
        chk("cw_data", 32'(bus.cw_data), 32'(bch_cw(wd[exp])));
        if (bus.cw_ready) begin
            exp_words++;
            @(negedge clk);
            chk("cw_valid_drop", 32'(bus.cw_valid), 32'd0);
            chk("busy_idle", 32'(bus.busy), 32'd0);
        end
    endtask

    typedef struct {
        logic [3:0] mask;
        int         exp;
    } vec_t;

    vec_t vt [12];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int te_first;
        int te_count;
        logic cw_seen;

        vt[0]  = '{4'b0001, 0};
        vt[1]  = '{4'b1111, 1};
        vt[2]  = '{4'b1111, 2};
        vt[3]  = '{4'b1111, 3};
        vt[4]  = '{4'b1111, 0};
        vt[5]  = '{4'b1010, 1};
        vt[6]  = '{4'b1010, 3};
        vt[7]  = '{4'b0101, 0};
        vt[8]  = '{4'b0100, 2};
        vt[9]  = '{4'b0011, 0};
        vt[10] = '{4'b1000, 3};
        vt[11] = '{4'b1001, 0};

        reset        = 1'b1;
        bus.req_valid = '0;
        bus.req_data  = {wd[3], wd[2], wd[1], wd[0]};
        bus.cw_ready  = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
        chk("rst_enc_start", 32'(bus.enc_start), 32'd0);
        chk("rst_cw_valid", 32'(bus.cw_valid), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_enc_data", 32'(bus.enc_data), 32'd0);
        reset = 1'b0;

        for (int v = 0; v < 12; v++) begin
            grant(vt[v].mask, vt[v].exp);
            finish_word(vt[v].exp);
        end

        // Backpressure: codeword held, no grants, late enc_done ignored.
        bus.cw_ready = 1'b0;
        grant(4'b1111, 1);
        finish_word(1);
        bus.req_valid = 4'b1111;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            chk("hold_cw_valid", 32'(bus.cw_valid), 32'd1);
            chk("hold_cw_data", 32'(bus.cw_data), 32'(bch_cw(wd[1])));
            chk("hold_cw_id", 32'(bus.cw_id), 32'd1);
            chk("hold_req_ready", 32'(bus.req_ready), 32'd0);
            frc_done = (c == 3);
        end
        frc_done     = 1'b0;
        bus.cw_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_cw_valid", 32'(bus.cw_valid), 32'd0);
        exp_words++;
        grant(4'b1111, 2);
        finish_word(2);

        // Timeout: encoder silent.
        enc_en = 1'b0;
        grant(4'b1000, 3);
        te_first = 0;
        te_count = 0;
        cw_seen  = 1'b0;
        for (int k = 1; k <= 80; k++) begin
            @(negedge clk);
            if (bus.timeout_err) begin
                te_count++;
                if (te_first == 0) te_first = k;
            end
            if (bus.cw_valid) cw_seen = 1'b1;
        end
        chk("timeout_cycle", 32'(te_first), 32'd67);
        chk("timeout_pulses", 32'(te_count), 32'd1);
        chk("timeout_no_cw", 32'(cw_seen), 32'd0);
        chk("timeout_busy", 32'(bus.busy), 32'd0);
        enc_en = 1'b1;
        grant(4'b1111, 0);
        finish_word(0);

`ifdef BCH_SCHED_STATS_EN
        chk("stat_words", 32'(stat_words), 32'(exp_words));
        chk("stat_timeouts", 32'(stat_timeouts), 32'd1);
`endif

        // Reset during WAIT discards the word and restarts round robin.
        enc_en = 1'b0;
        grant(4'b0100, 2);
        repeat (5) @(negedge clk);
        chk("pre_rst_busy", 32'(bus.busy), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        chk("mid_rst_enc_data", 32'(bus.enc_data), 32'd0);
        chk("mid_rst_cw_data", 32'(bus.cw_data), 32'd0);
        chk("mid_rst_cw_id", 32'(bus.cw_id), 32'd0);
        chk("mid_rst_cw_valid", 32'(bus.cw_valid), 32'd0);
        chk("mid_rst_timeout", 32'(bus.timeout_err), 32'd0);
        chk("mid_rst_busy", 32'(bus.busy), 32'd0);
`ifdef BCH_SCHED_STATS_EN
        chk("rst_stat_words", 32'(stat_words), 32'd0);
        chk("rst_stat_timeouts", 32'(stat_timeouts), 32'd0);
`endif
        reset  = 1'b0;
        enc_en = 1'b1;
        grant(4'b1010, 1);
        finish_word(1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/bch_enc_scheduler.md
Name: bch_enc_scheduler

Overview:
Shares one BCH(31,16) encoder between NUM_REQ requesters of 16-bit message words. Round-robin arbiter: accepts one word, drives the encoder's data/readready inputs, waits for outready, then presents the 31-bit codeword with the requester ID on a valid/ready output. Instantiated beside BCH_encoder in the transmit path; enc_* ports wire directly to that encoder's data, readready, outready and outdata.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
START_CYCLES, 2, cycles enc_start is held high per word (1..4)
TIMEOUT, 64, max cycles waiting for enc_done before the word is dropped (>=8)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-high
req_valid  input  NUM_REQ  per-requester word available
req_data  input  16*NUM_REQ  message words; requester i at bits [16i+15:16i]
req_ready  output  NUM_REQ  one-hot accept pulse; word i taken when req_valid[i]&req_ready[i]
enc_data  output  16  to encoder data
enc_start  output  1  to encoder readready
enc_done  input  1  from encoder outready
enc_codeword  input  31  from encoder outdata
cw_valid  output  1  codeword available
cw_ready  input  1  consumer accepts codeword
cw_data  output  31  codeword
cw_id  output  $clog2(NUM_REQ)  source requester of cw_data
timeout_err  output  1  one-cycle pulse on dropped word
busy  output  1  high in any state except IDLE

Behaviour:
- Reset (synchronous, sampled on clk rising edge, overrides everything): state=IDLE; req_ready=0, enc_data=0, enc_start=0, cw_valid=0, cw_data=0, cw_id=0, timeout_err=0, busy=0; last_grant=NUM_REQ-1 so the first grant goes to requester 0. Reset mid-operation discards the in-flight word; no codeword is emitted for it.
- States: IDLE, ISSUE, WAIT, HOLD.
- IDLE: if any req_valid, grant g = first set bit searching upward from last_grant+1 with wrap. req_ready[g]=1 combinationally in that cycle only; on the edge, latch req_data[g] into enc_data and g into cw_id, set last_grant=g, go ISSUE. No req_valid -> stay. req_ready is 0 in every other state.
- ISSUE: enc_start=1 for exactly START_CYCLES cycles; enc_data stable; then go WAIT with enc_start=0.
- WAIT: cycle counter from 0. enc_done=1 -> latch enc_codeword into cw_data, cw_valid=1, go HOLD. Counter reaching TIMEOUT-1 without enc_done -> timeout_err=1 for one cycle, go IDLE; word is lost and the requester is not re-granted ahead of its turn. enc_done on the same cycle as the timeout -> the codeword wins and no error.
- HOLD: cw_valid=1; cw_data and cw_id stable. cw_ready=1 -> cw_valid=0 next cycle, go IDLE. No new grant while in HOLD (backpressure stalls all requesters). enc_done here is ignored.
- Minimum accept-to-cw_valid latency: 1 + START_CYCLES + encoder latency. One word in flight at a time.
- enc_data retains the last word after completion; it is not cleared.

Optional Feature:
BCH_SCHED_STATS_EN: when defined, adds outputs stat_words (16-bit, incremented per completed cw handshake) and stat_timeouts (8-bit, incremented per timeout_err). Both counters saturate at all-ones and clear on reset. When undefined, these ports and counters do not exist and behaviour is otherwise identical.

Test Plan:
- Single word: reset 2 cycles; req_valid=0001, req_data[15:0]=16'd65 -> req_ready=0001 for 1 cycle; enc_start high 2 cycles with enc_data=65; cw_valid with cw_data equal to the encoder model codeword for 65, cw_id=0.
- Round robin: all four req_valid held high with distinct data, cw_ready=1 -> grant order 0,1,2,3,0; each cw_id matches its data.
- Backpressure: cw_ready=0 for 10 cycles after cw_valid -> cw_valid, cw_data, cw_id stable and req_ready stays 0; cw_ready=1 -> next grant follows.
- Timeout: enc_done tied 0, TIMEOUT=64 -> timeout_err pulses exactly 64 cycles after WAIT entry; cw_valid never rises; the next requester is granted next.
- Reset mid-WAIT: assert reset during WAIT -> all outputs 0 next cycle; req_valid=1010 afterwards -> grant to requester 1.
- BCH_SCHED_STATS_EN: 3 completed words plus 1 timeout -> stat_words=3, stat_timeouts=1; reset clears both.
